arbitro_mux: RTL and testbench

Round-robin arbiter that shares the 4-input, 16-bit datapath multiplexer between four requesters. It grants the shared path to one requester at a time and drives the multiplexer's 2-bit select so the granted requester's operand reaches the output. It sits beside the multiplexer: requesters talk to the arbiter, and the arbiter's `controle` feeds the multiplexer's `controle`. Each tenure is bounded by a burst limit so no requester can starve the others.

---
 rtl/arbitro_mux_pkg.sv | 30 +++
 rtl/arbitro_mux_seletor_rr.sv | 28 ++
 rtl/arbitro_mux.sv | 108 ++++++++++
 tb/tb_arbitro_mux.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/arbitro_mux_pkg.sv
// Shared constants for the round-robin arbiter in front of the 4:1 datapath mux.
package arbitro_mux_pkg;

    localparam int unsigned MAX_BURST_DEF = 8;

    // Arbiter state encoding
    localparam logic [0:0] LIVRE     = 1'b0;
    localparam logic [0:0] CONCEDIDO = 1'b1;

    // Requester indices, identical to the multiplexer select encoding
    localparam logic [1:0] SEL_ENTRADA0 = 2'b00;
    localparam logic [1:0] SEL_ENTRADA1 = 2'b01;
    localparam logic [1:0] SEL_ENTRADA2 = 2'b10;
    localparam logic [1:0] SEL_ENTRADA3 = 2'b11;

    // One-hot grant vector for a requester index
    function automatic logic [3:0] um_quente(input logic [1:0] indice);
        logic [3:0] resultado;
        resultado = 4'b0000;
        case (indice)
            SEL_ENTRADA0: resultado = 4'b0001;
            SEL_ENTRADA1: resultado = 4'b0010;
            SEL_ENTRADA2: resultado = 4'b0100;
            SEL_ENTRADA3: resultado = 4'b1000;
            default:      resultado = 4'b0000;
        endcase
        return resultado;
    endfunction

endpackage

// File: rtl/arbitro_mux_seletor_rr.sv
// Combinational round-robin search: ponteiro+1, +2, +3, then ponteiro itself,
// optionally skipping one index (the current owner on a handover).
module seletor_rr (
    input  logic [3:0] req,
    input  logic [1:0] ponteiro,
    input  logic       excluir,
    input  logic [1:0] excluido,
    output logic       valido,
    output logic [1:0] indice
);

    logic [1:0] candidato;

    // First requester in rotating order wins
    always_comb begin
        valido    = 1'b0;
        indice    = ponteiro;
        candidato = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            candidato = ponteiro + 2'(k);
            if (!valido && req[candidato] && !(excluir && (candidato == excluido))) begin
                valido = 1'b1;
                indice = candidato;
            end
        end
    end

endmodule

// File: rtl/arbitro_mux.sv
// Round-robin arbiter driving the select of the shared 4-input 16-bit mux,
// with a per-tenure burst limit under contention.
module arbitro_mux
    import arbitro_mux_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] controle,
    output logic       ocupado
);

    localparam int unsigned CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    logic [0:0]    estado, estado_nx;
    logic [1:0]    ultimo, ultimo_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    grant_nx;
    logic [1:0]    controle_nx;
    logic          ocupado_nx;

    logic          sel_valido;
    logic [1:0]    sel_indice;

    // While granted, ultimo is the owner; exclude it from the handover search
    seletor_rr u_seletor (
        .req      (req),
        .ponteiro (ultimo),
        .excluir  (estado == CONCEDIDO),
        .excluido (ultimo),
        .valido   (sel_valido),
        .indice   (sel_indice)
    );

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= LIVRE;
            ultimo   <= SEL_ENTRADA3;
            cnt      <= '0;
            grant    <= 4'b0000;
            controle <= SEL_ENTRADA0;
            ocupado  <= 1'b0;
        end else begin
            estado   <= estado_nx;
            ultimo   <= ultimo_nx;
            cnt      <= cnt_nx;
            grant    <= grant_nx;
            controle <= controle_nx;
            ocupado  <= ocupado_nx;
        end
    end

    // Next-state and next-output decision
    always_comb begin
        estado_nx   = estado;
        ultimo_nx   = ultimo;
        cnt_nx      = cnt;
        grant_nx    = grant;
        controle_nx = controle;
        ocupado_nx  = ocupado;

        case (estado)
            LIVRE: begin
                if (sel_valido) begin
                    estado_nx   = CONCEDIDO;
                    ultimo_nx   = sel_indice;
                    cnt_nx      = '0;
                    grant_nx    = um_quente(sel_indice);
                    controle_nx = sel_indice;
                    ocupado_nx  = 1'b1;
                end else begin
                    grant_nx   = 4'b0000;
                    ocupado_nx = 1'b0;
                end
            end
            CONCEDIDO: begin
                if (!req[ultimo] || ((cnt == CNT_MAX) && sel_valido)) begin
                    if (sel_valido) begin
                        // Direct handover, no idle bubble
                        ultimo_nx   = sel_indice;
                        cnt_nx      = '0;
                        grant_nx    = um_quente(sel_indice);
                        controle_nx = sel_indice;
                        ocupado_nx  = 1'b1;
                    end else begin
                        estado_nx  = LIVRE;
                        cnt_nx     = '0;
                        grant_nx   = 4'b0000;
                        ocupado_nx = 1'b0;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                estado_nx  = LIVRE;
                grant_nx   = 4'b0000;
                ocupado_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arbitro_mux.sv
// Scoreboard bench for arbitro_mux: directed vectors plus random-request invariant checks.
module tb_arbitro_mux;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] grant;
    logic [1:0] controle;
    logic       ocupado;

    always #5 clock = ~clock;

    arbitro_mux #(.MAX_BURST(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .controle (controle),
        .ocupado  (ocupado)
    );

    typedef struct {
        logic [3:0] g;
        logic [1:0] c;
        logic       o;
        int         id;
    } esperado_t;

    esperado_t sb[$];
    esperado_t e;
    int n_checks = 0;
    int n_fail   = 0;
    int step_id  = 0;
    int espera[4];

    // Apply one vector before the next edge and queue the expected outputs after it
    task automatic aplica(input logic rst, input logic [3:0] r,
                          input logic [3:0] g, input logic [1:0] c, input logic o);
        esperado_t x;
        @(negedge clock);
        reset = rst;
        req   = r;
        x.g = g; x.c = c; x.o = o; x.id = step_id;
        sb.push_back(x);
        step_id++;
    endtask

    // Monitor: compare queued expectations and always-on properties after each edge
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g) begin
                n_fail++;
                $display("FAIL grant step %0d: got %b expected %b", e.id, grant, e.g);
            end
            n_checks++;
            if (controle !== e.c) begin
                n_fail++;
                $display("FAIL controle step %0d: got %b expected %b", e.id, controle, e.c);
            end
            n_checks++;
            if (ocupado !== e.o) begin
                n_fail++;
                $display("FAIL ocupado step %0d: got %b expected %b", e.id, ocupado, e.o);
            end
        end
        n_checks++;
        if ((grant & (grant - 4'd1)) != 4'd0) begin
            n_fail++;
            $display("FAIL onehot at %0t: grant %b expected zero or one-hot", $time, grant);
        end
        n_checks++;
        if (ocupado !== (grant != 4'd0)) begin
            n_fail++;
            $display("FAIL ocupado_vs_grant at %0t: ocupado %b grant %b", $time, ocupado, grant);
        end
        n_checks++;
        if (ocupado && !grant[controle]) begin
            n_fail++;
            $display("FAIL grant_controle at %0t: grant %b controle %0d expected bit set", $time, grant, controle);
        end
        for (int i = 0; i < 4; i++) begin
            if (!reset) espera[i] = 0;
            else if (req[i] && !grant[i]) espera[i] = espera[i] + 1;
            else espera[i] = 0;
            n_checks++;
            if (espera[i] > 25) begin
                n_fail++;
                $display("FAIL espera req%0d at %0t: waited %0d cycles, limit 25", i, $time, espera[i]);
            end
        end
    end

    initial begin
        logic [1:0] dono;
        for (int i = 0; i < 4; i++) espera[i] = 0;

        // Reset held for two edges with all requesting
        aplica(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0);
        aplica(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0);

        // Fair rotation: 0,1,2,3,0 for 8 cycles each
        for (int k = 0; k < 40; k++) begin
            dono = 2'((k / 8) % 4);
            aplica(1'b1, 4'b1111, 4'(4'b0001 << dono), dono, 1'b1);
        end
        // Burst limit hands owner 0 over to 1
        aplica(1'b1, 4'b1111, 4'b0010, 2'b01, 1'b1);
        // Owner 1 releases with 3 pending: direct handover to 3
        aplica(1'b1, 4'b1001, 4'b1000, 2'b11, 1'b1);

        // Lone requester 2 for 40 cycles, never preempted
        for (int k = 0; k < 40; k++)
            aplica(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1);
        // Release to idle, controle holds
        aplica(1'b1, 4'b0000, 4'b0000, 2'b10, 1'b0);

        // Owner 2 regranted, then reset while cnt = 5
        for (int k = 0; k < 6; k++)
            aplica(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1);
        aplica(1'b0, 4'b0100, 4'b0000, 2'b00, 1'b0);
        aplica(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1);
        aplica(1'b1, 4'b0000, 4'b0000, 2'b10, 1'b0);

        // Random requests with sticky bits; invariants checked by the monitor
        for (int k = 0; k < 10000; k++) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        end

        @(negedge clock);
        req = 4'b0000;
        repeat (3) @(posedge clock);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
